// File: rtl/sd_file_matcher.sv
// sd_file_matcher: matches directory entries against a target name, BPC bytes per cycle.
// Define SD_FILE_MATCH_PREFIX_EN to accept entries whose name starts with the target.
module sd_file_matcher #(
  parameter int NAME_MAX = 52,
  parameter int BPC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NAME_MAX-1:0] tname,
  input  logic [7:0]            tnamelen,
  input  logic                  fready,
  input  logic [7:0]            fnamelen,
  input  logic [8*NAME_MAX-1:0] fname,
  input  logic [15:0]           fcluster,
  input  logic [31:0]           fsize,
  input  logic                  dir_end,
  output logic                  busy,
  output logic                  found,
  output logic                  miss,
  output logic [15:0]           match_cluster,
  output logic [31:0]           match_size,
  output logic [15:0]           entries,
  output logic                  overrun
);
  localparam logic [7:0] NM = 8'(NAME_MAX);
  typedef enum logic [1:0] {IDLE, ARMED, CMP} state_t;
  state_t state, state_nx;
  logic [8*NAME_MAX-1:0] tname_q, fname_q;
  logic [7:0] tnamelen_q, fnamelen_q, chunk;
  logic [15:0] fcluster_q;
  logic [31:0] fsize_q;
  logic pend, len_ok, tlen_ok, chunk_eq, last_chunk, found_nx, miss_nx;
`ifdef SD_FILE_MATCH_PREFIX_EN
  assign len_ok = fnamelen >= tnamelen_q;
`else
  assign len_ok = fnamelen == tnamelen_q;
`endif
  assign tlen_ok = tnamelen != 8'd0 && tnamelen <= NM;
  assign last_chunk = (int'(chunk) + 1) * BPC >= int'(tnamelen_q);
  assign busy = state != IDLE;
  // bytes past the target length are don't-care; a shorter snapshot can never match them
  always_comb begin
    chunk_eq = 1'b1;
    for (int j = 0; j < BPC; j++) begin
      int p;
      p = int'(chunk) * BPC + j;
      if (p < int'(tnamelen_q))
        if (p >= int'(fnamelen_q) || fname_q[8*p +: 8] != tname_q[8*p +: 8]) chunk_eq = 1'b0;
    end
  end
  always_comb begin
    state_nx = state;
    found_nx = 1'b0;
    miss_nx = 1'b0;
    if (start) begin
      state_nx = tlen_ok ? ARMED : IDLE;
      miss_nx = !tlen_ok;
    end else if (state == ARMED) begin
      if (dir_end) begin
        state_nx = IDLE;
        miss_nx = 1'b1;
      end else if (fready && len_ok) state_nx = CMP;
    end else if (state == CMP) begin
      if (!chunk_eq) begin
        state_nx = (pend || dir_end) ? IDLE : ARMED;
        miss_nx = pend || dir_end;
      end else if (last_chunk) begin
        state_nx = IDLE;
        found_nx = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      found <= 1'b0;
      miss <= 1'b0;
    end else begin
      state <= state_nx;
      found <= found_nx;
      miss <= miss_nx;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tname_q <= '0;
      tnamelen_q <= '0;
      fname_q <= '0;
      fnamelen_q <= '0;
      fcluster_q <= '0;
      fsize_q <= '0;
      chunk <= '0;
      pend <= 1'b0;
      entries <= '0;
      overrun <= 1'b0;
      match_cluster <= '0;
      match_size <= '0;
    end else if (start) begin
      tname_q <= tname;
      tnamelen_q <= tnamelen;
      entries <= '0;
      overrun <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (state == ARMED && fready && !dir_end) begin
        fname_q <= fname;
        fnamelen_q <= fnamelen;
        fcluster_q <= fcluster;
        fsize_q <= fsize;
        chunk <= '0;
        entries <= entries + 16'(entries != 16'hFFFF);
      end
      if (state == CMP) begin
        chunk <= chunk + 8'd1;
        pend <= state_nx == CMP && (pend || dir_end);
        if (fready) overrun <= 1'b1;
      end
      if (found_nx) begin
        match_cluster <= fcluster_q;
        match_size <= fsize_q;
      end
    end
endmodule

// File: doc/sd_file_matcher.md
SD_FILE_MATCHER -- requirements
Module: sd_file_matcher

Interface
REQ-001 SHALL have parameter NAME_MAX, default 52: width of the name byte arrays.
REQ-002 SHALL have parameter BPC, default 4: name bytes compared per cycle.
REQ-003 SHALL have port clk  in  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start  in  1: one-cycle pulse that arms a new search.
REQ-006 SHALL have ports tname  in  8xNAME_MAX, and tnamelen  in  8: the target name and its length.
REQ-007 SHALL have upstream directory-entry ports from the dir parser: fready in 1, fnamelen in 8, fname in 8xNAME_MAX, fcluster in 16, fsize in 32.
REQ-008 SHALL have port dir_end  in  1: pulse marking the end of the directory scan.
REQ-009 SHALL have port busy  out  1: high in ARMED or CMP.
REQ-010 SHALL have port found  out  1: one-cycle pulse on a match.
REQ-011 SHALL have port miss  out  1: one-cycle pulse when the search ends without a match.
REQ-012 SHALL have ports match_cluster  out  16, and match_size  out  32: the matched entry's cluster and size.
REQ-013 SHALL have port entries  out  16: entries seen since start, saturating at 16'hFFFF.
REQ-014 SHALL have port overrun  out  1: sticky flag, set when an entry is dropped.

Function
REQ-015 SHALL implement the FSM states IDLE, ARMED and CMP; found and miss are registered pulses issued on the exit transition.
REQ-016 SHALL, on start in any state, latch tname/tnamelen, clear entries and overrun, and enter ARMED next cycle; start has priority over all other inputs.
REQ-017 SHALL, when start arrives with tnamelen==0 or tnamelen>NAME_MAX, pulse miss the next cycle and return to IDLE.
REQ-018 SHALL, on fready in ARMED, snapshot fname/fnamelen/fcluster/fsize and increment entries.
REQ-019 SHALL, after that snapshot, return to ARMED without entering CMP if the length check fails (REQ-031).
REQ-020 SHALL, after that snapshot, otherwise enter CMP and compare BPC bytes per cycle from index 0, for N=ceil(tnamelen/BPC) cycles; bytes at index >= tnamelen are ignored.
REQ-021 SHALL, on the first mismatching chunk, abort the compare and return to ARMED on the next cycle.
REQ-022 SHALL, when all chunks match, latch match_cluster/match_size, pulse found one cycle after the last CMP cycle, and enter IDLE; with fready at edge t, found is high in cycle t+N+1.
REQ-023 SHALL keep match_cluster/match_size stable until the next found or reset; a miss leaves them unchanged.
REQ-024 SHALL, on fready during CMP, drop the entry, set overrun, and not count the entry.
REQ-025 SHALL, on dir_end in ARMED, pulse miss the next cycle and enter IDLE.
REQ-026 SHALL, on dir_end in CMP, record it as pending: a match completes with found only; no match pulses miss instead of returning to ARMED.
REQ-027 SHALL ignore fready and dir_end in IDLE.
REQ-028 SHALL never assert found and miss in the same cycle.

Reset
REQ-029 SHALL, on rst_n low, immediately force state IDLE, busy/found/miss/overrun=0, entries=0, match_cluster=0, match_size=0, and all snapshot and target registers to 0.
REQ-030 SHALL, on reset mid-search, discard the search with no pulse after release; a new start is required.

Configuration
REQ-031 SHALL provide macro SD_FILE_MATCH_PREFIX_EN; when defined, the length check passes if fnamelen >= tnamelen (prefix match); when undefined, it passes only if fnamelen == tnamelen (exact match).

Verification
REQ-032 SHALL cover: start with target "README.TXT" (len 10), then fready with the same name, cluster 16'h0123, size 32'd4096 -> found high exactly 4 cycles after fready (N=3), match_cluster=16'h0123, match_size=4096, entries=1.
REQ-033 SHALL cover: target "A.BIN", entries "B.BIN" then "A.BIN" 32 cycles apart, then dir_end -> one found for the second entry, no miss, entries=2.
REQ-034 SHALL cover: target "FOO", entry "FOOBAR" -> found with the macro defined; without the macro, no found, and a later dir_end -> miss one cycle later.
REQ-035 SHALL cover: a second fready 2 cycles into CMP -> overrun=1, entries unchanged by the second entry, first compare unaffected.
REQ-036 SHALL cover: rst_n low during CMP, then release -> all outputs 0, no found/miss afterwards; start with tnamelen=0 -> miss the next cycle.
